// File: rtl/ope_arbiter.sv
// rtl/ope_arbiter.sv - round-robin arbiter sharing one registered add-constant unit
module ope_arbiter #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] ADDEND = WIDTH'(5),
    parameter int               CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             busy,
    output logic             last_grant,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic             grant0, grant1;
    logic             handshake;
    logic             owner;
    logic [WIDTH-1:0] op_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] rsp0_hold, rsp1_hold;

    // On a tie the requester that did not win last time gets the unit.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if (last_grant) grant0 = 1'b1;
            else            grant1 = 1'b1;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign req0_ready = (state_q == IDLE) && grant0;
    assign req1_ready = (state_q == IDLE) && grant1;
    assign handshake  = req0_ready || req1_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (handshake) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            op_reg     <= '0;
            res_reg    <= '0;
            rsp0_hold  <= '0;
            rsp1_hold  <= '0;
            cnt0       <= '0;
            cnt1       <= '0;
        end else begin
            state_q <= state_d;
            if (handshake) begin
                op_reg     <= req1_ready ? req1_data : req0_data;
                owner      <= req1_ready;
                last_grant <= req1_ready;
                if (req0_ready && cnt0 != CNT_MAX) cnt0 <= cnt0 + CNT_W'(1);
                if (req1_ready && cnt1 != CNT_MAX) cnt1 <= cnt1 + CNT_W'(1);
            end
            if (state_q == EXEC) begin
                res_reg <= op_reg + ADDEND;
            end
            // Latch the result into the owner's hold register so data persists after the pulse.
            if (state_q == RESP) begin
                if (owner) rsp1_hold <= res_reg;
                else       rsp0_hold <= res_reg;
            end
        end
    end

    assign busy       = (state_q != IDLE);
    assign rsp0_valid = (state_q == RESP) && !owner;
    assign rsp1_valid = (state_q == RESP) && owner;
    assign rsp0_data  = rsp0_valid ? res_reg : rsp0_hold;
    assign rsp1_data  = rsp1_valid ? res_reg : rsp1_hold;

endmodule

// File: tb/tb_ope_arbiter.sv
// tb/tb_ope_arbiter.sv - scoreboard bench for ope_arbiter
module tb_ope_arbiter;

    localparam int WIDTH = 32;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req0_valid = 1'b0;
    logic [WIDTH-1:0] req0_data = '0;
    logic             req0_ready;
    logic             req1_valid = 1'b0;
    logic [WIDTH-1:0] req1_data = '0;
    logic             req1_ready;
    logic             rsp0_valid;
    logic [WIDTH-1:0] rsp0_data;
    logic             rsp1_valid;
    logic [WIDTH-1:0] rsp1_data;
    logic             busy;
    logic             last_grant;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    ope_arbiter #(.WIDTH(WIDTH), .ADDEND(32'd5), .CNT_W(CNT_W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .busy       (busy),
        .last_grant (last_grant),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        idx;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: invariants every cycle, pops scoreboard on every response pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            chk("ready_onehot", 32'(req0_ready && req1_ready), 32'd0);
            chk("rsp_onehot", 32'(rsp0_valid && rsp1_valid), 32'd0);
            if (rsp0_valid || rsp1_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp1_valid), 32'hDEAD);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_owner", 32'(rsp1_valid), 32'(e.idx));
                    chk("rsp_data", rsp1_valid ? rsp1_data : rsp0_data, e.data);
                    chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic do_op(input logic idx, input logic [31:0] data, input logic [31:0] expv);
        bit found;
        @(negedge clk);
        if (idx) begin req1_valid = 1'b1; req1_data = data; end
        else     begin req0_valid = 1'b1; req0_data = data; end
        #1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if ((idx ? req1_ready : req0_ready) === 1'b1) begin
                found = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        chk("handshake_timeout", 32'(found), 32'd1);
        if (found) sb.push_back('{idx, expv, cyc + 2});
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
    endtask

    initial begin
        bit          found;
        int          prev;
        logic        g;
        logic [3:0]  order;
        logic [7:0]  cexp;

        // 1: reset state
        do_reset();
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("rst_rsp0_data", rsp0_data, 32'd0);
        chk("rst_rsp1_data", rsp1_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_last_grant", 32'(last_grant), 32'd1);
        chk("rst_cnt0", 32'(cnt0), 32'd0);
        chk("rst_cnt1", 32'(cnt1), 32'd0);

        // 2: single op on requester 0, data 10 -> 15
        @(negedge clk);
        req0_valid = 1'b1;
        req0_data  = 32'd10;
        #1;
        chk("t2_ready0", 32'(req0_ready), 32'd1);
        chk("t2_ready1", 32'(req1_ready), 32'd0);
        sb.push_back('{1'b0, 32'd15, cyc + 2});
        @(negedge clk);
        req0_valid = 1'b0;
        req0_data  = 32'd99;
        #1;
        chk("t2_busy_t1", 32'(busy), 32'd1);
        chk("t2_cnt0", 32'(cnt0), 32'd1);
        chk("t2_last_grant", 32'(last_grant), 32'd0);
        @(negedge clk);
        #1;
        chk("t2_busy_t2", 32'(busy), 32'd1);
        chk("t2_rsp0_pulse", 32'(rsp0_valid), 32'd1);
        @(negedge clk);
        #1;
        chk("t2_busy_t3", 32'(busy), 32'd0);
        chk("t2_rsp0_after", 32'(rsp0_valid), 32'd0);
        chk("t2_rsp0_hold", rsp0_data, 32'd15);
        chk("t2_rsp1_data", rsp1_data, 32'd0);

        // 3: both held -> grants alternate 0,1,0,1 every 3 cycles
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 32'd1;
        req1_valid = 1'b1; req1_data = 32'd2;
        #1;
        order = 4'b1010;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            found = 0;
            for (int i = 0; i < 10; i++) begin
                if (req0_ready || req1_ready) begin
                    found = 1;
                    break;
                end
                @(negedge clk);
                #1;
            end
            chk("t3_timeout", 32'(found), 32'd1);
            g = req1_ready;
            chk("t3_grant", 32'(g), 32'(order[k]));
            if (k > 0) chk("t3_spacing", 32'(cyc - prev), 32'd3);
            prev = cyc;
            sb.push_back('{g, g ? 32'd7 : 32'd6, cyc + 2});
            @(negedge clk);
            #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("t3_cnt0", 32'(cnt0), 32'd2);
        chk("t3_cnt1", 32'(cnt1), 32'd2);
        chk("t3_rsp0_hold", rsp0_data, 32'd6);
        chk("t3_rsp1_hold", rsp1_data, 32'd7);

        // 4: wrap-around on requester 1
        do_op(1'b1, 32'hFFFF_FFFE, 32'h0000_0003);
        repeat (3) @(negedge clk);
        #1;
        chk("t4_rsp1_hold", rsp1_data, 32'h0000_0003);
        chk("t4_rsp0_unchanged", rsp0_data, 32'd6);

        // 5: reset during an operation drops it
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1;
        req0_data  = 32'd10;
        #1;
        chk("t5_ready0", 32'(req0_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_cnt0", 32'(cnt0), 32'd0);
        chk("t5_last_grant", 32'(last_grant), 32'd1);
        repeat (3) @(negedge clk);

        // 6: counter saturation with CNT_W=2
        do_reset();
        for (int k = 0; k < 5; k++) begin
            do_op(1'b0, 32'(k), 32'(k + 5));
            cexp = (k < 3) ? 8'(k + 1) : 8'd3;
            chk("t6_cnt0", 32'(cnt0), 32'(cexp));
            chk("t6_cnt1", 32'(cnt1), 32'd0);
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
